// File: rtl/keep_talking_pkg.sv
// Shared types and default timing constants for the front-panel button debouncer.
// Optional long-press detection is controlled by the LONG_PRESS_EN macro in the consumers.
package keep_talking_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_HELD      = 2'd2,
    ST_FALL_WAIT = 2'd3
  } deb_state_e;

  // About 24 ms and 1 s at the 27 MHz board clock.
  localparam int DEBOUNCE_CYCLES_DEF = 650000;
  localparam int LONG_CYCLES_DEF     = 27000000;

endpackage : keep_talking_pkg

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, debounce FSM with stability counter and,
// when LONG_PRESS_EN is defined, a saturating long-press counter.
module debounce_channel
  import keep_talking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef LONG_PRESS_EN
  ,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
`endif
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_in,
`ifdef LONG_PRESS_EN
  output logic long_press,
`endif
  output logic hold
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             sync;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_q, hold_d;

  // raw_in is asynchronous; only the second flop is ever looked at.
  assign sync_d = {sync_q[0], raw_in};
  assign sync   = sync_q[1];

  // NOTE: non-blocking assignments make every flop sample pre-edge values, so the
  // order of statements inside a clocked block never changes the hardware.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        hold_d = 1'b0;
        cnt_d  = '0;
        if (sync) state_d = ST_RISE_WAIT;
      end
      ST_RISE_WAIT: begin
        hold_d = 1'b0;
        if (!sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          hold_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        hold_d = 1'b1;
        cnt_d  = '0;
        if (!sync) state_d = ST_FALL_WAIT;
      end
      ST_FALL_WAIT: begin
        hold_d = 1'b1;
        if (sync) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          hold_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign hold = hold_q;

`ifdef LONG_PRESS_EN
  localparam int                LONG_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              long_press_q, long_press_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      long_cnt_q   <= '0;
      long_press_q <= 1'b0;
    end else begin
      long_cnt_q   <= long_cnt_d;
      long_press_q <= long_press_d;
    end
  end

  // Counts only while fully held; a release that is still being debounced freezes it.
  always_comb begin
    long_cnt_d   = long_cnt_q;
    long_press_d = long_press_q;
    case (state_q)
      ST_HELD: begin
        if (long_cnt_q != LONG_LAST) long_cnt_d = long_cnt_q + LONG_W'(1);
        if (long_cnt_d == LONG_LAST) long_press_d = 1'b1;
      end
      ST_FALL_WAIT: begin
        if (state_d == ST_IDLE) begin
          long_cnt_d   = '0;
          long_press_d = 1'b0;
        end
      end
      default: begin
        long_cnt_d   = '0;
        long_press_d = 1'b0;
      end
    endcase
  end

  assign long_press = long_press_q;
`endif

endmodule : debounce_channel

// File: rtl/button_debounce.sv
// Multi-channel synchronizer/debouncer for raw front-panel buttons; one independent
// debounce_channel per input. Long-press outputs exist only when LONG_PRESS_EN is defined.
module button_debounce
  import keep_talking_pkg::*;
#(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef LONG_PRESS_EN
  ,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
`endif
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] raw_in,
`ifdef LONG_PRESS_EN
  output logic [NUM_BUTTONS-1:0] long_press,
`endif
  output logic [NUM_BUTTONS-1:0] hold
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef LONG_PRESS_EN
      ,
      .LONG_CYCLES    (LONG_CYCLES)
`endif
    ) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .raw_in    (raw_in[i]),
`ifdef LONG_PRESS_EN
      .long_press(long_press[i]),
`endif
      .hold      (hold[i])
    );
  end

endmodule : button_debounce

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: a window model of the raw samples predicts hold
// (and long_press when LONG_PRESS_EN is defined) into a scoreboard checked after each edge.
module tb_button_debounce;

  localparam int NB    = 2;
  localparam int DEB   = 4;
  localparam int LONGC = 10;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] raw_in  = '0;
  logic [NB-1:0] hold;
`ifdef LONG_PRESS_EN
  logic [NB-1:0] long_press;
`endif

  always #5 clock = ~clock;

  button_debounce #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DEB)
`ifdef LONG_PRESS_EN
    ,
    .LONG_CYCLES    (LONGC)
`endif
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .raw_in    (raw_in),
`ifdef LONG_PRESS_EN
    .long_press(long_press),
`endif
    .hold      (hold)
  );

  typedef struct {
    logic [NB-1:0] hold;
    logic [NB-1:0] lp;
    bit            lp_chk;
  } exp_t;

  exp_t          sb[$];
  int            vectors     = 0;
  int            miscompares = 0;
  logic [15:0]   hist[NB];
  logic [NB-1:0] m_hold;
  int            since_rise[NB];
  bit            lp_chk_en;

  // Hold settles to v once the last DEB+1 samples seen by the FSM (two edges old) all equal v.
  task automatic drive(input logic [NB-1:0] raw, input logic rst_v);
    exp_t e;
    logic prev;
    @(negedge clock);
    raw_in  = raw;
    reset_n = rst_v;
    for (int c = 0; c < NB; c++) begin
      if (!rst_v) begin
        hist[c]       = '0;
        m_hold[c]     = 1'b0;
        since_rise[c] = 0;
      end else begin
        hist[c] = {hist[c][14:0], raw[c]};
        prev    = m_hold[c];
        if (&hist[c][DEB+2:2])        m_hold[c] = 1'b1;
        else if (~|hist[c][DEB+2:2])  m_hold[c] = 1'b0;
        if (m_hold[c] && !prev)       since_rise[c] = 0;
        else if (m_hold[c])           since_rise[c]++;
        else                          since_rise[c] = 0;
      end
      e.lp[c] = m_hold[c] && (since_rise[c] >= LONGC - 1);
    end
    e.hold   = m_hold;
    e.lp_chk = lp_chk_en;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    int   rise = -1;
    for (int i = 0; i < 13; i++) begin
      drive(2'b11, (i >= 3));
      e = sb.pop_front();
      vectors++;
      if (hold !== e.hold) begin
        miscompares++;
        $display("FAIL reset[%0d] hold got %b want %b", i, hold, e.hold);
      end
      if (i == 2) begin
        vectors++;
        if (hold !== 2'b00) begin
          miscompares++;
          $display("FAIL reset_state hold got %b want 00", hold);
        end
      end
      if (i >= 3 && rise < 0 && hold === 2'b11) rise = i - 3;
    end
    vectors++;
    if (rise !== 6) begin
      miscompares++;
      $display("FAIL reset_latency edges got %0d want 6", rise);
    end
  endtask

  task automatic test_short_glitch();
    exp_t e;
    bit   leaked = 1'b0;
    int   rise   = -1;
    for (int i = 0; i < 35; i++) begin
      logic [1:0] r;
      r = ((i >= 4 && i <= 6) || (i >= 15 && i <= 24)) ? 2'b01 : 2'b00;
      drive(r, (i >= 2));
      e = sb.pop_front();
      vectors++;
      if (hold !== e.hold) begin
        miscompares++;
        $display("FAIL glitch[%0d] hold got %b want %b", i, hold, e.hold);
      end
      if (i >= 4 && i <= 14 && hold[0] === 1'b1) leaked = 1'b1;
      if (i >= 15 && rise < 0 && hold[0] === 1'b1) rise = i - 15;
    end
    vectors++;
    if (leaked) begin
      miscompares++;
      $display("FAIL glitch_filtered hold[0] got 1 want 0");
    end
    vectors++;
    if (rise !== 6) begin
      miscompares++;
      $display("FAIL glitch_then_idle latency got %0d want 6", rise);
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    int   rise = -1;
    for (int i = 0; i < 17; i++) begin
      logic [1:0] r;
      r = (i >= 4 && i != 6) ? 2'b01 : 2'b00;
      drive(r, (i >= 2));
      e = sb.pop_front();
      vectors++;
      if (hold !== e.hold) begin
        miscompares++;
        $display("FAIL bounce[%0d] hold got %b want %b", i, hold, e.hold);
      end
      if (rise < 0 && hold[0] === 1'b1) rise = i - 7;
    end
    vectors++;
    if (rise !== 6) begin
      miscompares++;
      $display("FAIL bounce_restart latency got %0d want 6", rise);
    end
  endtask

  task automatic test_held_glitch();
    exp_t e;
    bit   dropped = 1'b0;
    int   fall    = -1;
    for (int i = 0; i < 38; i++) begin
      logic [1:0] r;
      r = ((i >= 4 && i <= 13) || (i >= 16 && i <= 25)) ? 2'b01 : 2'b00;
      drive(r, (i >= 2));
      e = sb.pop_front();
      vectors++;
      if (hold !== e.hold) begin
        miscompares++;
        $display("FAIL held_glitch[%0d] hold got %b want %b", i, hold, e.hold);
      end
      if (i >= 10 && i <= 31 && hold[0] !== 1'b1) dropped = 1'b1;
      if (i >= 26 && fall < 0 && hold[0] === 1'b0) fall = i - 26;
    end
    vectors++;
    if (dropped) begin
      miscompares++;
      $display("FAIL held_glitch_kept hold[0] got 0 want 1");
    end
    vectors++;
    if (fall !== 6) begin
      miscompares++;
      $display("FAIL release_latency got %0d want 6", fall);
    end
  endtask

  task automatic test_independent();
    exp_t e;
    int   rise0 = -1, rise1 = -1, fall0 = -1, fall1 = -1;
    for (int i = 0; i < 34; i++) begin
      logic [1:0] r;
      r[0] = (i >= 4 && i <= 20);
      r[1] = (i >= 4 && i <= 24 && i != 6);
      drive(r, (i >= 2));
      e = sb.pop_front();
      vectors++;
      if (hold !== e.hold) begin
        miscompares++;
        $display("FAIL indep[%0d] hold got %b want %b", i, hold, e.hold);
      end
      if (rise0 < 0 && hold[0] === 1'b1) rise0 = i - 4;
      if (rise1 < 0 && hold[1] === 1'b1) rise1 = i - 7;
      if (i >= 21 && fall0 < 0 && hold[0] === 1'b0) fall0 = i - 21;
      if (i >= 25 && fall1 < 0 && hold[1] === 1'b0) fall1 = i - 25;
    end
    vectors++;
    if (rise0 !== 6 || rise1 !== 6) begin
      miscompares++;
      $display("FAIL indep_rise got %0d/%0d want 6/6", rise0, rise1);
    end
    vectors++;
    if (fall0 !== 6 || fall1 !== 6) begin
      miscompares++;
      $display("FAIL indep_fall got %0d/%0d want 6/6", fall0, fall1);
    end
  endtask

  task automatic test_reset_mid_hold();
    exp_t e;
    int   rise = -1;
    for (int i = 0; i < 25; i++) begin
      drive((i >= 4) ? 2'b11 : 2'b00, (i >= 2 && i != 14));
      e = sb.pop_front();
      vectors++;
      if (hold !== e.hold) begin
        miscompares++;
        $display("FAIL mid_reset[%0d] hold got %b want %b", i, hold, e.hold);
      end
      if (i == 14) begin
        vectors++;
        if (hold !== 2'b00) begin
          miscompares++;
          $display("FAIL mid_reset_clear hold got %b want 00", hold);
        end
      end
      if (i >= 15 && rise < 0 && hold === 2'b11) rise = i - 15;
    end
    vectors++;
    if (rise !== 6) begin
      miscompares++;
      $display("FAIL mid_reset_fresh_press latency got %0d want 6", rise);
    end
  endtask

`ifdef LONG_PRESS_EN
  task automatic test_long_press();
    exp_t e;
    int   hrise = -1, lrise = -1, hfall = -1, lfall = -1;
    lp_chk_en = 1'b1;
    for (int i = 0; i < 54; i++) begin
      logic [1:0] r;
      r = ((i >= 4 && i <= 23) || (i >= 36 && i <= 52)) ? 2'b01 : 2'b00;
      drive(r, (i >= 2 && i != 52));
      e = sb.pop_front();
      vectors++;
      if (hold !== e.hold) begin
        miscompares++;
        $display("FAIL long[%0d] hold got %b want %b", i, hold, e.hold);
      end
      if (e.lp_chk) begin
        vectors++;
        if (long_press !== e.lp) begin
          miscompares++;
          $display("FAIL long[%0d] long_press got %b want %b", i, long_press, e.lp);
        end
      end
      if (i < 36) begin
        if (hrise < 0 && hold[0] === 1'b1)                   hrise = i;
        if (lrise < 0 && long_press[0] === 1'b1)             lrise = i;
        if (hrise >= 0 && hfall < 0 && hold[0] === 1'b0)     hfall = i;
        if (lrise >= 0 && lfall < 0 && long_press[0] === 1'b0) lfall = i;
      end
      if (i == 52) begin
        vectors++;
        if (hold !== 2'b00 || long_press !== 2'b00) begin
          miscompares++;
          $display("FAIL long_reset hold/long got %b/%b want 00/00", hold, long_press);
        end
      end
    end
    vectors++;
    if (lrise - hrise !== 9) begin
      miscompares++;
      $display("FAIL long_assert_delay got %0d want 9", lrise - hrise);
    end
    vectors++;
    if (lfall !== hfall || hfall !== 30) begin
      miscompares++;
      $display("FAIL long_clear_with_hold got long=%0d hold=%0d want 30/30", lfall, hfall);
    end
    lp_chk_en = 1'b0;
  endtask
`endif

  initial begin
    lp_chk_en = 1'b0;
    m_hold    = '0;
    for (int c = 0; c < NB; c++) begin
      hist[c]       = '0;
      since_rise[c] = 0;
    end
    test_reset();
    test_short_glitch();
    test_bounce();
    test_held_glitch();
    test_independent();
    test_reset_mid_hold();
`ifdef LONG_PRESS_EN
    test_long_press();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_button_debounce
